// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory port bundle for the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    // Load/store unit side.
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wdata, mem_read, mem_write
    );

    // CPU plus data-memory side.
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-organised data memory.
// Sub-word stores are done as read-modify-write.
//
// state | meaning
// IDLE  | ready for a request; errors are answered from here
// READ  | memory read: finish a load or merge the store lane(s)
// WRITE | memory write of a full or merged word
module load_store_unit #(
    parameter int MEM_SIZE_BIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic        req_err;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign req_err = (bus.req_size == 2'd3)
                  || ((bus.req_size == 2'd1) && bus.req_addr[0])
                  || ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00))
                  || (|bus.req_addr[31:MEM_SIZE_BIT+2]);

    // Lane extraction/extension for loads and lane merge for sub-word stores.
    always_comb begin
        byte_lane = bus.mem_rdata[{off_q, 3'b000} +: 8];
        half_lane = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_q)
            2'd0:    load_ext = {{24{signed_q & byte_lane[7]}}, byte_lane};
            2'd1:    load_ext = {{16{signed_q & half_lane[15]}}, half_lane};
            default: load_ext = bus.mem_rdata;
        endcase
        merged = bus.mem_rdata;
        if (size_q == 2'd0) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            off_q       <= 2'd0;
            wdata_q     <= 16'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next state: word stores skip READ, sub-word stores visit both.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !req_err) begin
                    state_d = (bus.req_write && (bus.req_size == 2'd2)) ? WRITE : READ;
                end
            end
            READ:    state_d = write_q ? WRITE : IDLE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latching, RMW merge and response generation.
    always_comb begin
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        write_d    = bus.req_write;
                        size_d     = bus.req_size;
                        signed_d   = bus.req_signed;
                        off_d      = bus.req_addr[1:0];
                        wdata_d    = bus.req_wdata[15:0];
                        mem_addr_d = {2'b00, bus.req_addr[31:2]};
                        if (bus.req_write && (bus.req_size == 2'd2)) begin
                            mem_wdata_d = bus.req_wdata;
                        end
                    end
                end
            end
            READ: begin
                if (write_q) begin
                    mem_wdata_d = merged;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_ext;
                end
            end
            WRITE:   rsp_valid_d = 1'b1;
            default: ;
        endcase
    end

    // Outputs: strobes decode straight from state so reset drops them at once.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.mem_read  = (state_q == READ);
        bus.mem_write = (state_q == WRITE);
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_err   = rsp_err_q;
        bus.rsp_rdata = rsp_rdata_q;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a response scoreboard and a
// behavioural data memory (combinational read, write on rising clk).
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    load_store_unit_if bus();

    load_store_unit #(.MEM_SIZE_BIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    assign bus.mem_rdata = (bus.mem_addr < 32'd256) ? mem[bus.mem_addr[7:0]] : 32'd0;
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] rdata;
        int          at;
    } exp_t;
    exp_t q[$];

    int          rd_n = 0;
    int          wr_n = 0;
    int          both_hi = 0;
    logic [31:0] last_raddr = 32'd0;
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] last_wdata = 32'd0;
    int          last_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: memory strobes and scoreboard comparison of each response.
    always @(negedge clk) begin
        if (bus.mem_read && bus.mem_write) both_hi++;
        if (bus.mem_read) begin
            rd_n++;
            last_raddr = bus.mem_addr;
        end
        if (bus.mem_write) begin
            wr_n++;
            last_waddr = bus.mem_addr;
            last_wdata = bus.mem_wdata;
        end
        if (bus.rsp_valid) begin
            chk("rsp_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk({e.tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
                chk({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
                chk({e.tag, "_cycle"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    // Present a request, hold it until accepted, queue the expected response.
    task automatic do_req(input string tag, input bit w, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit eerr, input logic [31:0] erd, input int lat);
        bit   acc = 1'b0;
        bit   rdy;
        exp_t e;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        for (int i = 0; i < 20; i++) begin
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk({tag, "_accept"}, 32'(acc), 32'd1);
        if (acc) begin
            last_acc = cyc;
            e.tag   = tag;
            e.err   = eerr;
            e.rdata = erd;
            e.at    = cyc + lat - 1;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    int rd0, wr0, acc_a;

    typedef struct {
        string       tag;
        logic [1:0]  sz;
        logic [31:0] a;
    } err_t;
    err_t errs[4];

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h01010101;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        reset = 1'b1;

        // Word load
        mem[4]   = 32'hDEADBEEF;
        mem[255] = 32'h0BADCAFE;
        rd0 = rd_n; wr0 = wr_n;
        do_req("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 2);
        wait_idle();
        chk("lw_10_reads", 32'(rd_n - rd0), 32'd1);
        chk("lw_10_writes", 32'(wr_n - wr0), 32'd0);
        chk("lw_10_addr", last_raddr, 32'd4);
        do_req("lw_3fc", 1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0, 1'b0, 32'h0BADCAFE, 2);
        wait_idle();

        // Sub-word loads with extension
        mem[4] = 32'h80FF1234;
        do_req("lb_13", 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 1'b0, 32'hFFFFFF80, 2);
        do_req("lbu_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 1'b0, 32'h00000080, 2);
        do_req("lh_12", 1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 1'b0, 32'hFFFF80FF, 2);
        do_req("lhu_12", 1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 1'b0, 32'h000080FF, 2);
        do_req("lh_10", 1'b0, 2'd1, 1'b1, 32'h10, 32'd0, 1'b0, 32'h00001234, 2);
        do_req("lb_11", 1'b0, 2'd0, 1'b1, 32'h11, 32'd0, 1'b0, 32'h00000012, 2);
        wait_idle();

        // Sub-word stores (upper wdata bits must be ignored)
        mem[4] = 32'h11223344;
        rd0 = rd_n; wr0 = wr_n;
        do_req("sb_11", 1'b1, 2'd0, 1'b1, 32'h11, 32'hFFFFFFAB, 1'b0, 32'd0, 3);
        wait_idle();
        chk("sb_11_reads", 32'(rd_n - rd0), 32'd1);
        chk("sb_11_writes", 32'(wr_n - wr0), 32'd1);
        chk("sb_11_wdata", last_wdata, 32'h1122AB44);
        chk("sb_11_waddr", last_waddr, 32'd4);
        chk("sb_11_mem", mem[4], 32'h1122AB44);
        mem[4] = 32'h11223344;
        do_req("sh_12", 1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD5566, 1'b0, 32'd0, 3);
        wait_idle();
        chk("sh_12_mem", mem[4], 32'h55663344);
        mem[7] = 32'h11223344;
        do_req("sb_1f", 1'b1, 2'd0, 1'b0, 32'h1F, 32'h000000C3, 1'b0, 32'd0, 3);
        wait_idle();
        chk("sb_1f_mem", mem[7], 32'hC3223344);

        // Error cases: no memory traffic, one-cycle answer
        errs[0] = '{tag: "err_sh_11", sz: 2'd1, a: 32'h11};
        errs[1] = '{tag: "err_lw_402", sz: 2'd2, a: 32'h402};
        errs[2] = '{tag: "err_lw_400", sz: 2'd2, a: 32'h400};
        errs[3] = '{tag: "err_size3", sz: 2'd3, a: 32'h0};
        for (int i = 0; i < 4; i++) begin
            rd0 = rd_n; wr0 = wr_n;
            do_req(errs[i].tag, (i == 0), errs[i].sz, 1'b0, errs[i].a, 32'h12345678,
                   1'b1, 32'd0, 1);
            wait_idle();
            chk({errs[i].tag, "_mem"}, 32'((rd_n - rd0) + (wr_n - wr0)), 32'd0);
        end

        // Back-to-back word store then load of the same word
        do_req("sw_0", 1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 32'd0, 2);
        acc_a = last_acc;
        do_req("lw_0", 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, 1'b0, 32'hCAFEF00D, 2);
        chk("b2b_gap", 32'(last_acc - acc_a), 32'd2);
        wait_idle();

        // Reset during the WRITE cycle of a byte store
        mem[4] = 32'h11223344;
        do_req("sb_rst", 1'b1, 2'd0, 1'b0, 32'h11, 32'h000000EE, 1'b0, 32'd0, 3);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_write_before", 32'(bus.mem_write), 32'd1);
        q.delete();
        reset = 1'b0;
        #1;
        chk("rst_mid_write_after", 32'(bus.mem_write), 32'd0);
        chk("rst_mid_read_after", 32'(bus.mem_read), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_mem", mem[4], 32'h11223344);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
        do_req("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 32'h11223344, 2);
        wait_idle();

        chk("rw_exclusive", 32'(both_hi), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end for the word-organised data memory. It accepts one CPU memory request at a time (byte, halfword or word; load or store), checks alignment and range, and drives the memory's word-index address/read/write port. Loads are returned sign- or zero-extended. Sub-word stores are done as a two-step read-modify-write. It sits between the CPU's MEM stage and the data memory, whose read data is combinational and whose writes commit on the rising clk edge.

## Interface
- MEM_SIZE_BIT, 8: log2 of memory depth in 32-bit words; valid byte addresses are 0 .. 4*2^MEM_SIZE_BIT-1.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 halfword, 2 word, 3 illegal.
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  qualifies rsp_valid: misaligned, out-of-range or illegal size.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_addr  out  32  word index {2'b0, addr[31:2]}.
- mem_wdata  out  32  full word to write.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_rdata  in  32  combinational read data from memory.

## Operation
- FSM states: IDLE, READ, WRITE. Request fields are latched on acceptance (req_valid && req_ready at a rising edge).
- Error check happens at acceptance. An error is any of:
  - req_size==3;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:MEM_SIZE_BIT+2] nonzero.
- On error: no memory access, the FSM stays in IDLE, and rsp_valid=1 with rsp_err=1 and rsp_rdata=0 in the following cycle.
- Load → READ: mem_read=1 with mem_addr driven. At the edge, extract the lane from mem_rdata, extend it, register it into rsp_rdata, pulse rsp_valid, and return to IDLE.
- Byte lanes are little-endian:
  - byte offset k selects bits [8k+7:8k];
  - halfword offset 0 selects [15:0], offset 2 selects [31:16].
- Word store → WRITE: mem_write=1 and mem_wdata=req_wdata. At the edge, pulse rsp_valid and return to IDLE.
- Sub-word store → READ, then WRITE:
  - READ: capture mem_rdata and replace the addressed lane(s) with req_wdata[7:0] or [15:0]. Other bytes are preserved.
  - WRITE: mem_write=1 with the merged word.
  - Then pulse rsp_valid and return to IDLE.
- req_signed is ignored for stores. req_wdata bits above the store size are ignored.
- mem_read and mem_write are never both high, and are low in IDLE. mem_addr and mem_wdata hold their last latched values when idle.

## Timing
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_addr=0; mem_wdata=0; mem_read=0; mem_write=0.
- Acceptance edge is E0. Latency to rsp_valid high:
  - error: cycle after E0 (1);
  - load or word store: cycle after E1 (2);
  - sub-word store: cycle after E2 (3).
- rsp_valid is high for exactly one cycle. The FSM is already in IDLE during that cycle, so a new request may be accepted at the same edge that ends the pulse (back-to-back, no bubble).
- req_valid while req_ready=0 is ignored and not queued. The requester must hold it until accepted.
- Reset asserted mid-operation asynchronously forces IDLE and drops mem_write/mem_read immediately. An interrupted RMW leaves memory unmodified, and no rsp_valid is produced for it.
- Reset deassertion is taken synchronously. First acceptance is possible at the first rising edge with reset=1.

## Test plan
- lw 0x10 with mem[4]=0xDEADBEEF → mem_read for 1 cycle, mem_addr=4; rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- lb signed 0x13 and lbu 0x13 with mem[4]=0x80FF1234 → rsp_rdata=0xFFFFFF80 and 0x00000080 respectively; lh signed 0x12 → 0xFFFF80FF.
- sb 0x11 with wdata 0x000000AB over mem[4]=0x11223344 → READ then WRITE; mem_wdata=0x1122AB44, rsp_valid 3 cycles after accept; sh 0x12 with wdata 0x5566 → 0x55663344 (from the original word).
- Errors, each with no mem_read/mem_write and rsp_valid+rsp_err the next cycle:
  - sh 0x11;
  - lw 0x402 (misaligned);
  - lw 0x400 (out of range, MEM_SIZE_BIT=8);
  - req_size=3.
- Back-to-back sw 0x0 then lw 0x0 with the second req_valid held → second accepted in the sw's rsp_valid cycle; returns the stored value.
- Reset pulled low during the WRITE cycle of an sb → mem_write falls immediately, memory word unchanged, no rsp_valid, req_ready=1 after release.
